// File: rtl/mod_mult_pkg.sv
// Shared widths, stage payload and helpers for the Barrett modular multiplier pipeline.
// Stage payload carries x, q, r, m, k and u together so that config changes only affect newly sampled operands.
package mod_mult_pkg;

    localparam int DATA_W    = 32;
    localparam int PP_STAGES = 6;
    localparam int PROD_W    = 2 * DATA_W;
    localparam int Q_W       = DATA_W + 1;
    localparam int R_W       = DATA_W + 2;
    localparam int K_W       = 6;
    localparam int U_W       = 64;
    localparam int Q2_W      = Q_W + R_W;

    typedef struct packed {
        logic [PROD_W-1:0] x;
        logic [Q_W-1:0]    q;
        logic [R_W-1:0]    r;
        logic [DATA_W-1:0] m;
        logic [K_W-1:0]    k;
        logic [U_W-1:0]    u;
    } stage_t;

    function automatic logic [R_W-1:0] cond_sub(input logic [R_W-1:0] r, input logic [R_W-1:0] m);
        return (r >= m) ? (r - m) : r;
    endfunction

endpackage

// File: rtl/mod_mult_stage_reg.sv
// One pipeline stage register: async active-low reset, synchronous clear, hold when disabled.
// Clear has priority over enable so a flush always wins over an advance.
module mod_mult_stage_reg #(
    parameter int W = 1
) (
    input  logic         iClk,
    input  logic         iRstN,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            data_q <= '0;
        end else if (clr_i) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mod_mult_barrett_32b_pp.sv
// Pipelined (a*b) mod m via Barrett reduction; 6 enabled edges from sample to oData, one pair per cycle.
// No backpressure: iEn=0 holds every stage, iClr flushes to zero; MODMUL_ASSERT_EN compiles in sim checks.
module mod_mult_barrett_32b_pp
    import mod_mult_pkg::*;
(
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iEn,
    input  logic              iClr,
    input  logic [K_W-1:0]    iK,
    input  logic [U_W-1:0]    iU,
    input  logic [DATA_W-1:0] iData0,
    input  logic [DATA_W-1:0] iData1,
    input  logic [DATA_W-1:0] iMod,
    output logic [DATA_W-1:0] oData
);

    localparam int SW = $bits(stage_t);

    stage_t            s1_d, s1_q, s2_d, s2_q, s3_d, s3_q, s4_d, s4_q, s5_d, s5_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic [Q_W-1:0]    q1;
    logic [Q2_W-1:0]   q2;
    logic [K_W:0]      shr_hi;
    logic [R_W-1:0]    m_ext;
    logic [R_W-1:0]    r_fix;

    // Stage 1 keeps a and b packed in x until the product is formed.
    always_comb begin
        s1_d   = '0;
        s1_d.x = {iData0, iData1};
        s1_d.m = iMod;
        s1_d.k = iK;
        s1_d.u = iU;
    end

    always_comb begin
        s2_d   = s1_q;
        s2_d.x = {{DATA_W{1'b0}}, s1_q.x[PROD_W-1:DATA_W]} * {{DATA_W{1'b0}}, s1_q.x[DATA_W-1:0]};
    end

    always_comb begin
        q1     = Q_W'(s2_q.x >> (s2_q.k - K_W'(1)));
        q2     = {{R_W{1'b0}}, q1} * {{Q_W{1'b0}}, s2_q.u[R_W-1:0]};
        shr_hi = {1'b0, s2_q.k} + (K_W+1)'(1);
        s3_d   = s2_q;
        s3_d.q = Q_W'(q2 >> shr_hi);
    end

    // r < 3m fits in R_W bits, so only the low R_W bits of p = q3*m are kept.
    always_comb begin
        s4_d   = s3_q;
        s4_d.r = R_W'({{DATA_W{1'b0}}, s3_q.q} * {{Q_W{1'b0}}, s3_q.m});
    end

    always_comb begin
        s5_d   = s4_q;
        s5_d.r = s4_q.x[R_W-1:0] - s4_q.r;
    end

    always_comb begin
        m_ext  = {2'b00, s5_q.m};
        r_fix  = cond_sub(cond_sub(s5_q.r, m_ext), m_ext);
        data_d = DATA_W'(r_fix);
    end

    mod_mult_stage_reg #(.W(SW)) u_stg1 (.iClk(iClk), .iRstN(iRstN), .clr_i(iClr), .en_i(iEn), .d_i(s1_d), .q_o(s1_q));
    mod_mult_stage_reg #(.W(SW)) u_stg2 (.iClk(iClk), .iRstN(iRstN), .clr_i(iClr), .en_i(iEn), .d_i(s2_d), .q_o(s2_q));
    mod_mult_stage_reg #(.W(SW)) u_stg3 (.iClk(iClk), .iRstN(iRstN), .clr_i(iClr), .en_i(iEn), .d_i(s3_d), .q_o(s3_q));
    mod_mult_stage_reg #(.W(SW)) u_stg4 (.iClk(iClk), .iRstN(iRstN), .clr_i(iClr), .en_i(iEn), .d_i(s4_d), .q_o(s4_q));
    mod_mult_stage_reg #(.W(SW)) u_stg5 (.iClk(iClk), .iRstN(iRstN), .clr_i(iClr), .en_i(iEn), .d_i(s5_d), .q_o(s5_q));
    mod_mult_stage_reg #(.W(DATA_W)) u_stg6 (.iClk(iClk), .iRstN(iRstN), .clr_i(iClr), .en_i(iEn), .d_i(data_d), .q_o(data_q));

    assign oData = data_q;

    // Fields that are dead by the last stage; synthesis prunes their flops.
    logic unused_s5;
    assign unused_s5 = ^{s5_q.x, s5_q.q, s5_q.k, s5_q.u};

`ifdef MODMUL_ASSERT_EN
    function automatic logic s5_legal(input stage_t s);
        logic [2*PROD_W-1:0] pow;
        logic                k_ok;
        k_ok = (s.k >= K_W'(2)) && (s.k <= K_W'(32)) && ((s.m >> (s.k - K_W'(1))) == DATA_W'(1));
        pow  = (2*PROD_W)'(1) << (2 * s.k);
        return k_ok && (s.u == U_W'(pow / {{(2*PROD_W-DATA_W){1'b0}}, s.m}))
                    && (s.x < ({{DATA_W{1'b0}}, s.m} * {{DATA_W{1'b0}}, s.m}));
    endfunction

    always @(posedge iClk) begin
        if (iRstN && iEn && !iClr) begin
            assert ((iK >= K_W'(2)) && (iK <= K_W'(32)) && ((iMod >> (iK - K_W'(1))) == DATA_W'(1)))
                else $error("modmul: k/m out of range at sampling, k=%0d m=%0h", iK, iMod);
            if (s5_legal(s5_q)) begin
                assert (s5_q.r < (R_W'(3) * m_ext))
                    else $error("modmul: more than two corrections needed, r=%0h m=%0h", s5_q.r, s5_q.m);
                assert (r_fix < m_ext)
                    else $error("modmul: result %0h not below m=%0h", r_fix, s5_q.m);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mod_mult_barrett_32b_pp.sv
// Directed bench for the Barrett modular multiplier: reset, latency, config-with-data, stall, flush, async reset.
module tb_mod_mult_barrett_32b_pp;
    import mod_mult_pkg::*;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        iEn;
    logic        iClr;
    logic [5:0]  iK;
    logic [63:0] iU;
    logic [31:0] iData0;
    logic [31:0] iData1;
    logic [31:0] iMod;
    logic [31:0] oData;

    int checks = 0;
    int errors = 0;
    logic [31:0] pipe [PP_STAGES];

    mod_mult_barrett_32b_pp dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iEn    (iEn),
        .iClr   (iClr),
        .iK     (iK),
        .iU     (iU),
        .iData0 (iData0),
        .iData1 (iData1),
        .iMod   (iMod),
        .oData  (oData)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [5:0] k, input logic [63:0] u, input logic [31:0] m);
        iK   = k;
        iU   = u;
        iMod = m;
    endtask

    task automatic clear_model();
        foreach (pipe[i]) pipe[i] = '0;
    endtask

    // Drive one cycle, advance the expected-result delay line, compare oData.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic en, input logic clr);
        iData0 = a;
        iData1 = b;
        iEn    = en;
        iClr   = clr;
        @(posedge iClk);
        #1;
        if (clr) begin
            clear_model();
        end else if (en) begin
            for (int i = PP_STAGES - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = exp;
        end
        chk(tag, oData, pipe[PP_STAGES-1]);
    endtask

    task automatic rnd_step(input string tag);
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        a    = $urandom % iMod;
        b    = $urandom % iMod;
        prod = ({32'd0, a} * {32'd0, b}) % {32'd0, iMod};
        step(tag, a, b, prod[31:0], 1'b1, 1'b0);
    endtask

    initial begin
        logic [127:0] u_wide;
        logic [63:0]  u_fb;

        u_wide = (128'd1 << 64) / {96'd0, 32'hFFFF_FFFB};
        u_fb   = u_wide[63:0];
        clear_model();

        iRstN  = 1'b0;
        iEn    = 1'b1;
        iClr   = 1'b0;
        iData0 = '0;
        iData1 = '0;
        set_cfg(6'd32, 64'h1_0000_0001, 32'hFFFF_FFFF);
        #1;
        chk("reset_t0", oData, 32'd0);

        repeat (20) begin
            iData0 = $urandom;
            iData1 = $urandom;
            iK     = 6'($urandom);
            iU     = {$urandom, $urandom};
            iMod   = $urandom;
            iEn    = 1'($urandom);
            iClr   = 1'($urandom);
            @(posedge iClk);
            #1;
            chk("reset_hold", oData, 32'd0);
        end

        iRstN = 1'b1;
        set_cfg(6'd32, 64'h1_0000_0001, 32'hFFFF_FFFF);
        step("lat_m1_sq", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 1'b1, 1'b0);
        step("lat_b_zero", 32'hFFFF_FFFE, 32'd0, 32'd0, 1'b1, 1'b0);
        set_cfg(6'd13, 64'd8736, 32'd7681);
        step("lat_k13", 32'd1467, 32'd2489, 32'd2888, 1'b1, 1'b0);

        set_cfg(6'd32, u_fb, 32'hFFFF_FFFB);
        for (int i = 0; i < 100; i++) rnd_step("rand_k32");

        for (int i = 0; i < 3; i++) step("stall_hold", $urandom, $urandom, 32'hDEAD_BEEF, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) rnd_step("stall_resume");

        step("flush", $urandom % iMod, $urandom % iMod, 32'd0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) rnd_step("post_flush");

        @(negedge iClk);
        iRstN = 1'b0;
        #1;
        chk("async_rst", oData, 32'd0);
        @(posedge iClk);
        #1;
        chk("async_rst_edge", oData, 32'd0);
        iRstN = 1'b1;
        clear_model();
        for (int i = 0; i < 8; i++) rnd_step("post_rst");
        for (int i = 0; i < PP_STAGES; i++) step("drain", 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
